// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write-port bundle for the boot loader.
interface mem_loader_if #(
   parameter int unsigned BUS_WIDTH = 32
);
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 mem_we;
   logic [BUS_WIDTH-1:0] mem_a;
   logic [BUS_WIDTH-1:0] mem_wd;

   // Stream source / memory side
   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_a, mem_wd
   );

   // Loader side
   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/mem_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream and writes
// little-endian 32-bit words into memory at consecutive word addresses.
module mem_loader #(
   parameter int unsigned BUS_WIDTH = 32,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 16384
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   mem_loader_if.slave      bus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      words_written
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   state_t              state;
   logic [1:0]          byte_cnt;
   logic [23:0]         asm_q;
   logic [WORD_W-1:0]   len_q;
   logic [IDX_W-1:0]    idx;
   logic                hs_c;
   logic [WORD_W-1:0]   word_c;

   // Byte transfer qualifier and the word completed by the current byte
   assign hs_c   = bus.in_valid && bus.in_ready;
   assign word_c = {bus.in_data, asm_q};

   // Loader FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         byte_cnt      <= 2'd0;
         asm_q         <= 24'd0;
         len_q         <= 32'd0;
         idx           <= 16'd0;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_a     <= BUS_WIDTH'(ADDR_BASE);
         bus.mem_wd    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= 16'd0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state         <= LEN;
                  byte_cnt      <= 2'd0;
                  idx           <= 16'd0;
                  words_written <= 16'd0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  error         <= 1'b0;
               end
            end
            LEN: begin
               if (hs_c) begin
                  asm_q    <= word_c[31:8];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     len_q <= word_c;
                     if (word_c == 32'd0) begin
                        state        <= DONE;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                     end else if (word_c > 32'(MAX_WORDS)) begin
                        state        <= ERR;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
            end
            DATA: begin
               if (hs_c) begin
                  asm_q    <= word_c[31:8];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state        <= WRITE;
                     bus.in_ready <= 1'b0;
                     bus.mem_we   <= 1'b1;
                     bus.mem_a    <= BUS_WIDTH'(ADDR_BASE + 32'({idx, 2'b00}));
                     bus.mem_wd   <= BUS_WIDTH'(word_c);
                  end
               end
            end
            WRITE: begin
               bus.mem_we    <= 1'b0;
               idx           <= idx + 16'd1;
               words_written <= words_written + 16'd1;
               if (32'(idx) + 32'd1 == len_q) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state        <= DATA;
                  bus.in_ready <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
               bus.mem_we   <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader against a stream-level model.
module tb_mem_loader;
   localparam int unsigned MAX_W = 16384;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   mem_loader_if #(.BUS_WIDTH(32)) bus ();

   mem_loader #(
      .BUS_WIDTH (32),
      .ADDR_BASE (32'h0000_0000),
      .MAX_WORDS (MAX_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0]  stream [$];
   logic [31:0] exp_a [$];
   logic [31:0] exp_d [$];
   logic        exp_done;
   logic        exp_err;
   logic [31:0] exp_ww;
   logic [31:0] obs_a [$];
   logic [31:0] obs_d [$];
   int          obs_c [$];
   logic [31:0] tb_mem [0:63];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every memory write (mem_we is sampled once per cycle)
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         obs_a.push_back(bus.mem_a);
         obs_d.push_back(bus.mem_wd);
         obs_c.push_back(cyc);
         tb_mem[bus.mem_a[7:2]] = bus.mem_wd;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Build a stream: 4-byte length field followed by nwords random words
   task automatic make_stream(input logic [31:0] n, input int nwords);
      logic [31:0] w;
      stream.delete();
      for (int k = 0; k < 4; k++) stream.push_back(n[8*k +: 8]);
      for (int i = 0; i < nwords; i++) begin
         w = $urandom;
         for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
      end
   endtask

   // Reference: what a correct loader must write for the current stream
   task automatic model();
      logic [31:0] n;
      logic [31:0] w;
      exp_a.delete();
      exp_d.delete();
      n = {stream[3], stream[2], stream[1], stream[0]};
      exp_done = (n != 0) && (n <= MAX_W) ? 1'b1 : (n == 0);
      exp_err  = (n > MAX_W);
      exp_ww   = exp_err ? 32'd0 : n;
      if (!exp_err) begin
         for (int i = 0; i < int'(n); i++) begin
            w = {stream[4+4*i+3], stream[4+4*i+2], stream[4+4*i+1], stream[4+4*i]};
            exp_a.push_back(32'(i) * 32'd4);
            exp_d.push_back(w);
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      obs_a.delete();
      obs_d.delete();
      obs_c.delete();
   endtask

   // Feed the first nbytes of the stream, honouring the handshake
   task automatic send(input int nbytes, input int valid_pct, input bit stray);
      int  i = 0;
      int  budget = 0;
      bit  hs;
      while (i < nbytes) begin
         @(negedge clk);
         bus.in_valid = ($urandom_range(1, 100) <= valid_pct);
         bus.in_data  = bus.in_valid ? stream[i] : 8'($urandom);
         if (stray && busy && ($urandom_range(0, 4) == 0)) start = 1'b1;
         hs = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         start        = 1'b0;
         if (hs) i++;
         budget++;
         if (budget > 3000) begin
            check("send_timeout", 32'(i), 32'(nbytes));
            break;
         end
      end
   endtask

   task automatic wait_end();
      int k = 0;
      while (!(done || error) && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (!(done || error)) check("end_timeout", 32'(k), 32'd0);
   endtask

   task automatic check_result(input string tag);
      check({tag, "_wr_count"}, 32'(obs_a.size()), 32'(exp_a.size()));
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
         check({tag, "_wr_a"}, obs_a[i], exp_a[i]);
         check({tag, "_wr_d"}, obs_d[i], exp_d[i]);
      end
      check({tag, "_done"}, 32'(done), 32'(exp_done));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_words"}, 32'(words_written), exp_ww);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_a"}, bus.mem_a, 32'd0);
      check({tag, "_wd"}, bus.mem_wd, 32'd0);
      check({tag, "_words"}, 32'(words_written), 32'd0);
   endtask

   initial begin
      logic [31:0] n;
      int          nw;
      int          kind;
      logic [31:0] w0;

      rst_n        = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals("rst");

      // Two-word directed load, valid always high
      stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      model();
      pulse_start();
      send(stream.size(), 100, 1'b0);
      wait_end();
      check_result("two");
      check("two_word1", 32'(obs_d.size() > 1 ? obs_d[1] : 32'h0), 32'hDEAD_BEEF);
      check("two_rdback", tb_mem[1], 32'hDEAD_BEEF);
      if (obs_c.size() == 2) check("two_spacing", 32'(obs_c[1] - obs_c[0]), 32'd5);

      // Zero length: done on the cycle after the 4th byte
      make_stream(32'd0, 0);
      model();
      pulse_start();
      send(4, 100, 1'b0);
      @(negedge clk);
      check("zero_done_next", 32'(done), 32'd1);
      check_result("zero");

      // Oversize length goes to ERR, then a valid load recovers
      make_stream(32'd16385, 0);
      model();
      pulse_start();
      send(4, 100, 1'b0);
      @(negedge clk);
      check("big_err_next", 32'(error), 32'd1);
      check_result("big");
      make_stream(32'd1, 1);
      model();
      pulse_start();
      send(stream.size(), 100, 1'b0);
      wait_end();
      check_result("recover");

      // Gappy single-word load with stray start pulses
      make_stream(32'd1, 1);
      model();
      pulse_start();
      send(stream.size(), 40, 1'b1);
      wait_end();
      check_result("gappy");

      // Randomized loads
      for (int it = 0; it < 10; it++) begin
         kind = $urandom_range(0, 7);
         if (kind == 6) begin
            n = 32'd0; nw = 0;
         end else if (kind == 7) begin
            n = $urandom_range(32'hFFFF_FFFF, MAX_W + 1); nw = 0;
         end else begin
            nw = $urandom_range(1, 6); n = 32'(nw);
         end
         make_stream(n, nw);
         model();
         pulse_start();
         send(stream.size(), $urandom_range(30, 100), 1'b1);
         wait_end();
         check_result("rand");
      end

      // Reset after 6 payload bytes of a 3-word load
      make_stream(32'd3, 3);
      w0 = {stream[7], stream[6], stream[5], stream[4]};
      pulse_start();
      send(10, 100, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_wr_count", 32'(obs_a.size()), 32'd1);
      check("midrst_mem0", tb_mem[0], w0);
      check("midrst_idle_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
